// File: rtl/mips32_pkg.sv
// Shared types and constants for the pipe_MIPS32 front end.
// Opcodes, fetch-state encoding and the fetch-entry bundle.
package mips32_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_HLT  = 6'h3f;
    localparam logic [5:0] OP_ADDI = 6'h0a;
    localparam logic [5:0] OP_LW   = 6'h08;
    localparam logic [5:0] OP_SW   = 6'h09;
    localparam logic [5:0] OP_OR   = 6'h03;

    typedef enum logic [1:0] {
        FETCH,
        HALT_PEND,
        HALTED
    } if_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        npc;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [5:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_if_fifo.sv
// Prefetch FIFO: DEPTH fetch entries, push/pop/flush, occupancy count.
// Ports: clk, rst_n, push_i, data_i, pop_i, flush_i, head_o, count_o.
module mips32_if_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    // Flush wins over push; a same-cycle pop still saw the old head.
    always_comb begin
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        if (flush_i) count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/mips32_if_stage.sv
// Instruction fetch: PC, credit-limited imem reads, prefetch FIFO,
// redirect flush and HLT stop. Ports: clk1, rst_n, imem_req/addr/rdata/
// rvalid, br_taken/target, id_valid/instr/npc/ready, halted.
// Optional MIPS_IF_PERF_EN adds perf_fetch_cnt and perf_flush_cnt.
module mips32_if_stage
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk1,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_npc,
    input  logic            id_ready,
    output logic            halted
`ifdef MIPS_IF_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_state_t       state_q;
    logic [PC_W-1:0] pc_q;
    logic            go_q;
    logic            infl_q;
    logic [PC_W-1:0] infl_addr_q;
    logic            halted_q;

    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    entry;
    logic [PC_W-1:0] npc_next;
    logic            redirect;
    logic            pop;
    logic            push;
    logic            hlt_push;
    logic            hlt_pop;
    logic            credit;

    always_comb begin
        id_valid = count != '0;
        pop      = id_valid && id_ready;
        hlt_pop  = pop && is_hlt(head.instr[31:26]);
        // A HLT retiring this cycle wins over a late redirect.
        redirect = br_taken && (state_q != HALTED) && !hlt_pop;
        // The kill: a word arriving during a redirect is dropped.
        push     = imem_rvalid && infl_q && !redirect;
        hlt_push = push && is_hlt(imem_rdata[31:26]);
        // Pops free a slot only from the next cycle on.
        credit   = (count + CW'(infl_q)) < CW'(DEPTH);
        imem_req = go_q && (state_q == FETCH) && !redirect
                   && !hlt_push && credit;
        npc_next = infl_addr_q + PC_W'(1);
        entry.instr = imem_rdata;
        entry.npc   = 32'(npc_next);
        id_instr = id_valid ? head.instr : '0;
        id_npc   = id_valid ? head.npc[PC_W-1:0] : '0;
    end

    assign imem_addr = pc_q;
    assign halted    = halted_q;

    mips32_if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk1),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .head_o  (head),
        .count_o (count)
    );

    // go_q gives a synchronous release: no request in the reset cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            go_q        <= 1'b0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            go_q        <= 1'b1;
            infl_q      <= imem_req;
            infl_addr_q <= pc_q;
            if (redirect)      pc_q <= br_target;
            else if (imem_req) pc_q <= pc_q + PC_W'(1);
            unique case (state_q)
                FETCH: begin
                    if (hlt_push) state_q <= HALT_PEND;
                end
                HALT_PEND: begin
                    if (hlt_pop) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (redirect) begin
                        state_q <= FETCH;
                    end
                end
                HALTED: state_q <= HALTED;
                default: state_q <= FETCH;
            endcase
        end
    end

`ifdef MIPS_IF_PERF_EN
    logic discard;
    assign discard = redirect && ((count > CW'(pop)) || infl_q);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (discard && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_if_stage.sv
// Directed bench for mips32_if_stage with a 1-cycle imem model.
// Optional perf counter checks under MIPS_IF_PERF_EN.
module tb_mips32_if_stage;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_npc;
    logic        id_ready = 1'b0;
    logic        halted;
`ifdef MIPS_IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [31:0] req_log [$];
    logic        pend_req = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] prog [8] = '{
        32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
        32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000
    };

    mips32_if_stage #(.DEPTH(4), .PC_W(32)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_npc      (id_npc),
        .id_ready    (id_ready),
        .halted      (halted)
`ifdef MIPS_IF_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    // Sample the request mid-cycle, after the bench has driven inputs.
    always @(negedge clk1) begin
        #2;
        pend_req  = rst_n && imem_req;
        pend_addr = imem_addr;
        if (rst_n && imem_req) req_log.push_back(imem_addr);
    end

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= pend_req;
            imem_rdata  <= mem[pend_addr[7:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mem[i] = {6'h03, 26'(i)};
        for (int i = 0; i < 8; i++) mem[i] = prog[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_ready = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        repeat (2) @(negedge clk1);
        req_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk1);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b want 0", imem_req);
        end
        checks++;
        if (imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_addr got %h want 0", imem_addr);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", id_valid);
        end
        checks++;
        if (id_instr !== 32'd0 || id_npc !== 32'd0) begin
            errors++;
            $display("FAIL rst_id got %h/%h want 0/0", id_instr, id_npc);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL rst_halted got %b want 0", halted);
        end
    endtask

    task automatic test_program();
        int k = 0;
        bit seen8 = 0;
        load_mem();
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 60 && k < 8; c++) begin
            @(negedge clk1);
            #1;
            if (id_valid === 1'b1) begin
                checks++;
                if (id_instr !== prog[k]) begin
                    errors++;
                    $display("FAIL prog_instr%0d got %h want %h",
                             k, id_instr, prog[k]);
                end
                checks++;
                if (id_npc !== 32'(k + 1)) begin
                    errors++;
                    $display("FAIL prog_npc%0d got %0d want %0d",
                             k, id_npc, k + 1);
                end
                k++;
            end
        end
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL prog_timeout got %0d want 8 pops", k);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL prog_halt_early got %b want 0", halted);
        end
        @(negedge clk1);
        #1;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL prog_halted got %b want 1", halted);
        end
        repeat (5) @(negedge clk1);
        #3;
        foreach (req_log[i]) if (req_log[i] == 32'd8) seen8 = 1;
        checks++;
        if (seen8 || req_log.size() != 8) begin
            errors++;
            $display("FAIL prog_no_addr8 got %0d reqs seen8=%0b want 8/0",
                     req_log.size(), seen8);
        end
        checks++;
        if (halted !== 1'b1 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL prog_sticky got %b/%b want 1/0",
                     halted, id_valid);
        end
    endtask

    task automatic test_stall();
        load_mem();
        do_reset();
        repeat (10) @(negedge clk1);
        #1;
        checks++;
        if (req_log.size() != 4) begin
            errors++;
            $display("FAIL stall_reqs got %0d want 4", req_log.size());
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== 32'(i)) begin
                errors++;
                $display("FAIL stall_addr%0d got %0d want %0d",
                         i, req_log[i], i);
            end
        end
        checks++;
        if (id_valid !== 1'b1 || id_instr !== 32'h28010078) begin
            errors++;
            $display("FAIL stall_hold got %b/%h want 1/28010078",
                     id_valid, id_instr);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (id_valid !== 1'b1 || id_instr !== prog[i]) begin
                errors++;
                $display("FAIL stall_drain%0d got %b/%h want 1/%h",
                         i, id_valid, id_instr, prog[i]);
            end
            @(negedge clk1);
            #1;
        end
        id_ready = 1'b0;
    endtask

    task automatic test_redirect();
        load_mem();
        do_reset();
        for (int c = 0; c < 20 && req_log.size() < 4; c++) begin
            @(negedge clk1);
            #3;
        end
        @(negedge clk1);
        br_taken = 1'b1;
        br_target = 32'd120;
        #1;
        checks++;
        if (id_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_pre got valid=%b req=%b want 1/0",
                     id_valid, imem_req);
        end
        @(negedge clk1);
        br_taken = 1'b0;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush got %b want 0", id_valid);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd120) begin
            errors++;
            $display("FAIL redir_addr got %b/%0d want 1/120",
                     imem_req, imem_addr);
        end
`ifdef MIPS_IF_PERF_EN
        checks++;
        if (perf_fetch_cnt !== 32'd3 || perf_flush_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_cnt got %0d/%0d want 3/1",
                     perf_fetch_cnt, perf_flush_cnt);
        end
`endif
        id_ready = 1'b1;
        for (int c = 0; c < 10 && id_valid !== 1'b1; c++) begin
            @(negedge clk1);
            #1;
        end
        checks++;
        if (id_valid !== 1'b1 || id_npc !== 32'd121
            || id_instr !== mem[120]) begin
            errors++;
            $display("FAIL redir_first got %b/%0d/%h want 1/121/%h",
                     id_valid, id_npc, id_instr, mem[120]);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_hlt_redirect();
        load_mem();
        mem[2] = 32'hfc000000;
        do_reset();
        repeat (10) @(negedge clk1);
        #1;
        checks++;
        if (req_log.size() != 3 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hlt_stop got %0d reqs req=%b want 3/0",
                     req_log.size(), imem_req);
        end
        @(negedge clk1);
        br_taken = 1'b1;
        br_target = 32'd40;
        @(negedge clk1);
        br_taken = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd40) begin
            errors++;
            $display("FAIL hlt_resume got %b/%0d want 1/40",
                     imem_req, imem_addr);
        end
        id_ready = 1'b1;
        for (int c = 0; c < 10 && id_valid !== 1'b1; c++) begin
            @(negedge clk1);
            #1;
        end
        checks++;
        if (id_valid !== 1'b1 || id_npc !== 32'd41) begin
            errors++;
            $display("FAIL hlt_npc got %b/%0d want 1/41", id_valid, id_npc);
        end
        repeat (4) @(negedge clk1);
        #1;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_halted got %b want 0", halted);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        load_mem();
        do_reset();
        for (int c = 0; c < 20 && req_log.size() < 4; c++) begin
            @(negedge clk1);
            #3;
        end
        checks++;
        if (id_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got %b want 1", id_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'd0 || id_valid !== 1'b0
            || id_instr !== 32'd0 || id_npc !== 32'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL arst_zero got %b %h %b %h %h %b want all 0",
                     imem_req, imem_addr, id_valid, id_instr, id_npc, halted);
        end
        @(negedge clk1);
        req_log.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk1);
        #3;
        checks++;
        if (req_log.size() == 0) begin
            errors++;
            $display("FAIL arst_first got none want addr 0");
        end else if (req_log[0] !== 32'd0) begin
            errors++;
            $display("FAIL arst_first got %0d want 0", req_log[0]);
        end
    endtask

    initial begin
        load_mem();
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_hlt_redirect();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_if_stage.md
Name: mips32_if_stage

Overview:
- Instruction-fetch front end for the pipe_MIPS32 core. Feeds the decode stage.
- Owns the PC and issues word-addressed reads to instruction memory.
- Buffers returned words in a small prefetch FIFO and hands them to decode with a valid/ready handshake.
- Handles branch redirect/flush and HLT detection. This lets programs run without dummy-instruction padding on the fetch side.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, min 2).
- PC_W, 32, PC width; word address, increments by 1.

Ports:
- clk1  in  1  single fetch clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  PC_W  word address of request.
- imem_rdata  in  32  instruction word.
- imem_rvalid  in  1  rdata valid; exactly 1 cycle after imem_req.
- br_taken  in  1  one-cycle redirect pulse from EX.
- br_target  in  PC_W  redirect word address.
- id_valid  out  1  FIFO head valid.
- id_instr  out  32  FIFO head instruction.
- id_npc  out  PC_W  head address + 1.
- id_ready  in  1  decode accepts head.
- halted  out  1  sticky HLT-retired flag.

Behaviour:
- Reset (async assert, sync release):
  - PC=0; FIFO empty; in-flight=0; state=FETCH.
  - imem_req=0, imem_addr=0, id_valid=0, id_instr=0, id_npc=0, halted=0.
- Credit rule: imem_req=1 only in state FETCH and when (count + inflight) < DEPTH. A pop in the same cycle does not add credit.
- On issue: imem_addr=PC, and PC<=PC+1 at the clock edge. PC wraps modulo 2^PC_W.
- Response: when imem_rvalid=1 and the kill bit is clear, push {rdata, addr+1}.
  - Address comes from a 1-deep in-flight register.
- Decode handshake: pop when id_valid && id_ready. id_* are driven combinationally from the FIFO head.
  - The head is stable while id_valid && !id_ready.
- Push and pop in the same cycle are permitted at any occupancy. Overflow is impossible under the credit rule.
- HLT detection: opcode [31:26]==6'h3f.
  - Pushing a HLT moves the state to HALT_PEND and stops further requests.
  - Popping a HLT moves the state to HALTED and sets halted=1.
  - Entries behind a HLT are never fetched.
- States and transitions:
  - FETCH -> HALT_PEND on HLT push.
  - HALT_PEND -> HALTED on HLT pop.
  - HALT_PEND -> FETCH on br_taken.
  - HALTED is terminal until reset.
- Redirect (br_taken=1 in FETCH or HALT_PEND):
  - Next edge: FIFO cleared, PC<=br_target, state=FETCH.
  - An outstanding request's response arriving next cycle is discarded via the kill bit.
  - A pop in the same cycle as br_taken completes (decode consumed it); all other entries are flushed.
  - No request is issued in the br_taken cycle.
  - The first request from br_target is issued the cycle after.
- br_taken in HALTED is ignored.
- imem_rvalid without an outstanding request is ignored.

Optional Feature:
- Macro MIPS_IF_PERF_EN.
- When defined: two extra outputs.
  - perf_fetch_cnt (32) counts accepted pushes.
  - perf_flush_cnt (32) counts redirects that discarded at least one entry or in-flight word.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package mips32_pkg:
  - Opcode constants: HLT=6'h3f, ADDI=6'h0a, LW=6'h08, SW=6'h09, OR=6'h03.
  - INSTR_W=32.
  - if_state_t enum {FETCH, HALT_PEND, HALTED}.
  - Fetch-entry struct {instr, npc}.
- Sub-module mips32_if_fifo:
  - Synchronous FIFO, DEPTH entries, with push/pop/flush and count.
  - flush has priority over push; a pop in the same cycle as flush still returns the old head.

Test Plan:
- Reset, then memory model returns Mem[0..7] = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000, with id_ready=1 -> id_instr sequence matches, id_npc=1..8. halted=1 the cycle after HLT pops. imem_req never issued for address 8.
- id_ready=0 for 10 cycles -> exactly DEPTH=4 requests (addr 0..3), id_instr held at 28010078. Releasing id_ready drains 4 entries in 4 cycles.
- br_taken=1, br_target=120 while FIFO holds 3 entries and one is in flight -> FIFO empty next cycle, in-flight word dropped, next imem_addr=120, next id_npc=121.
- HLT at address 2, then br_taken to 40 before the HLT pops -> state returns to FETCH, halted stays 0, fetch resumes at 40.
- Assert rst_n low mid-stream with 2 entries buffered -> all outputs zero immediately (asynchronous). After release, first imem_addr=0.
- With MIPS_IF_PERF_EN defined, run test 3 -> perf_fetch_cnt equals total pushes, perf_flush_cnt=1.
